// File: rtl/round_robin_arbiter_n.sv
// N-requester round-robin arbiter with optional grant locking and a bounded hold time.
// Grants are combinational from requests and state; state advances on the rising clock edge.
module round_robin_arbiter_n #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     requests,
    input  logic             lock,
    output logic [N-1:0]     grants,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [IDX_W-1:0] pointer_q, pointer_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             held_q, held_d;

    logic             owner_req;
    logic             others_req;
    logic             below_limit;
    logic             hold_path;
    logic             scan_found;
    logic [IDX_W-1:0] scan_idx;

    always_comb begin
        owner_req  = 1'b0;
        others_req = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (i == int'(owner_q)) begin
                owner_req = requests[i];
            end else if (requests[i]) begin
                others_req = 1'b1;
            end
        end
        below_limit = (int'(hold_cnt_q) + 1) < int'(MAX_HOLD);
        hold_path   = held_q && owner_req && (below_limit || !others_req);
    end

    // Rotating priority scan starting at pointer; the wrap uses an explicit compare so
    // non-power-of-two N never produces an out-of-range index.
    always_comb begin : scan
        int j;
        j          = 0;
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int k = 0; k < int'(N); k++) begin
            j = int'(pointer_q) + k;
            if (j >= int'(N)) begin
                j = j - int'(N);
            end
            if (!scan_found && requests[j]) begin
                scan_found = 1'b1;
                scan_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        pointer_d   = pointer_q;
        owner_d     = owner_q;
        hold_cnt_d  = hold_cnt_q;
        if (rst) begin
            grant_valid = 1'b0;
        end else if (hold_path) begin
            grant_valid = 1'b1;
            grant_idx   = owner_q;
            if (below_limit) begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
        end else if (scan_found) begin
            grant_valid = 1'b1;
            grant_idx   = scan_idx;
            owner_d     = scan_idx;
            hold_cnt_d  = '0;
            pointer_d   = (scan_idx == IDX_W'(N - 1)) ? '0 : scan_idx + IDX_W'(1);
        end
        held_d = grant_valid && lock;
    end

    always_comb begin
        grants = '0;
        for (int i = 0; i < int'(N); i++) begin
            grants[i] = grant_valid && (int'(grant_idx) == i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pointer_q  <= '0;
            owner_q    <= '0;
            hold_cnt_q <= '0;
            held_q     <= 1'b0;
        end else begin
            pointer_q  <= pointer_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            held_q     <= held_d;
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Directed bench for round_robin_arbiter_n: five instances with different N / MAX_HOLD share
// one stimulus bus; a vector table selects which instance is compared each cycle.
module tb_round_robin_arbiter_n;

    logic       clk;
    logic       rst;
    logic       lock;
    logic [3:0] req;

    logic [3:0] g_a, g_c, g_d;
    logic [1:0] g_b;
    logic [2:0] g_e;
    logic [1:0] i_a, i_c, i_d, i_e;
    logic       i_b;
    logic       v_a, v_b, v_c, v_d, v_e;

    round_robin_arbiter_n #(.N(4), .MAX_HOLD(4)) u_a (
        .clk(clk), .rst(rst), .requests(req), .lock(lock),
        .grants(g_a), .grant_valid(v_a), .grant_idx(i_a)
    );
    round_robin_arbiter_n #(.N(2), .MAX_HOLD(4)) u_b (
        .clk(clk), .rst(rst), .requests(req[1:0]), .lock(lock),
        .grants(g_b), .grant_valid(v_b), .grant_idx(i_b)
    );
    round_robin_arbiter_n #(.N(4), .MAX_HOLD(3)) u_c (
        .clk(clk), .rst(rst), .requests(req), .lock(lock),
        .grants(g_c), .grant_valid(v_c), .grant_idx(i_c)
    );
    round_robin_arbiter_n #(.N(4), .MAX_HOLD(2)) u_d (
        .clk(clk), .rst(rst), .requests(req), .lock(lock),
        .grants(g_d), .grant_valid(v_d), .grant_idx(i_d)
    );
    round_robin_arbiter_n #(.N(3), .MAX_HOLD(4)) u_e (
        .clk(clk), .rst(rst), .requests(req[2:0]), .lock(lock),
        .grants(g_e), .grant_valid(v_e), .grant_idx(i_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         cur_dut;
    logic [3:0] act_g;
    logic [1:0] act_i;
    logic       act_v;

    always_comb begin
        act_g = '0;
        act_i = '0;
        act_v = 1'b0;
        case (cur_dut)
            0: begin act_g = g_a;           act_i = i_a;           act_v = v_a; end
            1: begin act_g = {2'b00, g_b};  act_i = {1'b0, i_b};   act_v = v_b; end
            2: begin act_g = g_c;           act_i = i_c;           act_v = v_c; end
            3: begin act_g = g_d;           act_i = i_d;           act_v = v_d; end
            4: begin act_g = {1'b0, g_e};   act_i = i_e;           act_v = v_e; end
            default: begin act_g = '0; act_i = '0; act_v = 1'b0; end
        endcase
    end

    typedef struct {
        int         dut;
        logic       rst;
        logic       lock;
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] idx;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    task automatic add(input int d, input logic r, input logic l, input logic [3:0] q,
                       input logic [3:0] g, input logic [1:0] x);
        vec_t v;
        v.dut  = d;
        v.rst  = r;
        v.lock = l;
        v.req  = q;
        v.g    = g;
        v.idx  = x;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ei);
        logic ev;
        ev = |eg;
        total++;
        if (act_g !== eg || act_i !== ei || act_v !== ev) begin
            bad++;
            $display("FAIL %s dut=%0d: got grants=%b idx=%0d valid=%b, want grants=%b idx=%0d valid=%b",
                     name, cur_dut, act_g, act_i, act_v, eg, ei, ev);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        @(negedge clk);
        cur_dut = v.dut;
        rst     = v.rst;
        lock    = v.lock;
        req     = v.req;
        #1;
        check(name, v.g, v.idx);
    endtask

    initial begin
        vec_t v;
        total   = 0;
        bad     = 0;
        cur_dut = 0;
        rst     = 1'b1;
        lock    = 1'b0;
        req     = '0;

        // N=4, MAX_HOLD=4: reset, plain rotation, idle, early release
        add(0, 1, 0, 4'b1111, 4'b0000, 2'd0);
        add(0, 0, 0, 4'b1111, 4'b0001, 2'd0);
        add(0, 0, 0, 4'b1111, 4'b0010, 2'd1);
        add(0, 0, 0, 4'b1111, 4'b0100, 2'd2);
        add(0, 0, 0, 4'b1111, 4'b1000, 2'd3);
        add(0, 0, 0, 4'b1111, 4'b0001, 2'd0);
        add(0, 0, 1, 4'b0000, 4'b0000, 2'd0);
        add(0, 0, 0, 4'b1111, 4'b0010, 2'd1);
        add(0, 1, 0, 4'b0000, 4'b0000, 2'd0);
        add(0, 0, 1, 4'b1110, 4'b0010, 2'd1);
        add(0, 0, 1, 4'b1110, 4'b0010, 2'd1);
        add(0, 0, 0, 4'b1101, 4'b0100, 2'd2);
        add(0, 0, 0, 4'b1111, 4'b1000, 2'd3);
        // N=2 pure round-robin sequence
        add(1, 1, 0, 4'b0000, 4'b0000, 2'd0);
        add(1, 0, 0, 4'b0001, 4'b0001, 2'd0);
        add(1, 0, 0, 4'b0000, 4'b0000, 2'd0);
        add(1, 0, 0, 4'b0010, 4'b0010, 2'd1);
        add(1, 0, 0, 4'b0011, 4'b0001, 2'd0);
        add(1, 0, 0, 4'b0011, 4'b0010, 2'd1);
        add(1, 0, 0, 4'b0000, 4'b0000, 2'd0);
        add(1, 0, 0, 4'b0011, 4'b0001, 2'd0);
        add(1, 0, 0, 4'b0000, 4'b0000, 2'd0);
        add(1, 0, 0, 4'b0011, 4'b0010, 2'd1);
        add(1, 0, 0, 4'b0011, 4'b0001, 2'd0);
        // N=4, MAX_HOLD=3: locked owners rotate every three cycles
        add(2, 1, 0, 4'b0000, 4'b0000, 2'd0);
        for (int k = 0; k < 12; k++) begin
            logic [3:0] one;
            one = 4'b0001 << (k / 3);
            add(2, 0, 1, 4'b1111, one, 2'(k / 3));
        end
        add(2, 0, 1, 4'b1111, 4'b0001, 2'd0);
        // N=4, MAX_HOLD=2: sole requester keeps the grant past the limit
        add(3, 1, 0, 4'b0000, 4'b0000, 2'd0);
        for (int k = 0; k < 6; k++) begin
            add(3, 0, 1, 4'b0100, 4'b0100, 2'd2);
        end
        add(3, 0, 1, 4'b0101, 4'b0001, 2'd0);
        // N=3 wrap without a power-of-two index space
        add(4, 1, 0, 4'b0000, 4'b0000, 2'd0);
        add(4, 0, 0, 4'b0111, 4'b0001, 2'd0);
        add(4, 0, 0, 4'b0111, 4'b0010, 2'd1);
        add(4, 0, 0, 4'b0111, 4'b0100, 2'd2);
        add(4, 0, 0, 4'b0111, 4'b0001, 2'd0);

        foreach (vecs[n]) begin
            apply($sformatf("vec%0d", n), vecs[n]);
        end

        // Asynchronous reset in the middle of a locked hold on N=4, MAX_HOLD=3
        v = '{dut: 2, rst: 1'b1, lock: 1'b0, req: 4'b0000, g: 4'b0000, idx: 2'd0};
        apply("mid_pre_rst", v);
        v = '{dut: 2, rst: 1'b0, lock: 1'b1, req: 4'b1110, g: 4'b0010, idx: 2'd1};
        apply("mid_hold0", v);
        apply("mid_hold1", v);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_async_rst", 4'b0000, 2'd0);
        for (int k = 0; k < 4; k++) begin
            v = '{dut: 2, rst: 1'b0, lock: 1'b1, req: 4'b1111,
                  g: (k < 3) ? 4'b0001 : 4'b0010, idx: (k < 3) ? 2'd0 : 2'd1};
            apply($sformatf("mid_post%0d", k), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
